// File: rtl/muller_c_bank_if.sv
// Channel bundle for muller_c_bank: C-element inputs, mode/clear controls and
// registered observation outputs, grouped so a bench or wrapper drives one port.
interface muller_c_bank_if #(
    parameter int CHANNELS = 2,
    parameter int INPUTS   = 3,
    parameter int CNT_W    = 8
);
    logic [CHANNELS*INPUTS-1:0] io_in;
    logic [CHANNELS-1:0]        mode;
    logic                       clr_cnt;
    logic [CHANNELS-1:0]        io_out;
    logic [CHANNELS*CNT_W-1:0]  toggle_cnt;
    logic [CHANNELS-1:0]        stuck;

    modport master (
        output io_in, mode, clr_cnt,
        input  io_out, toggle_cnt, stuck
    );

    modport slave (
        input  io_in, mode, clr_cnt,
        output io_out, toggle_cnt, stuck
    );
endinterface

// File: rtl/muller_c_bank.sv
// Bank of clocked Muller C-elements with per-channel symmetric/asymmetric fall,
// saturating transition counters and a consecutive-disagreement stall detector.
module muller_c_bank #(
    parameter int   CHANNELS  = 2,
    parameter int   INPUTS    = 3,
    parameter logic RESET_VAL = 1'b0,
    parameter int   CNT_W     = 8,
    parameter int   STALL_CYC = 15
) (
    input  logic            clock,
    input  logic            reset_n,
    muller_c_bank_if.slave  bus
);
    localparam int SW = $clog2(STALL_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [SW-1:0]    STALL_MAX = SW'(STALL_CYC);
    localparam logic [SW-1:0]    STALL_ONE = SW'(1);

    logic [CHANNELS-1:0]             io_out_q, io_out_d;
    logic [CHANNELS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [CHANNELS-1:0][SW-1:0]     stall_q, stall_d;
    logic [CHANNELS-1:0]             stuck_q, stuck_d;

    logic [CHANNELS-1:0][INPUTS-1:0] slice_s;
    logic [CHANNELS-1:0]             all1_s, all0_s, rest0_s;

    // Per-channel C-element evaluation, counter and stall-detector next state
    always_comb begin
        io_out_d = io_out_q;
        cnt_d    = cnt_q;
        stall_d  = stall_q;
        stuck_d  = stuck_q;
        slice_s  = '0;
        all1_s   = '0;
        all0_s   = '0;
        rest0_s  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            slice_s[c] = bus.io_in[c*INPUTS +: INPUTS];
            all1_s[c]  = &slice_s[c];
            rest0_s[c] = ~(|slice_s[c][INPUTS-1:1]);
            // Asymmetric mode lets the falling edge ignore the plus input (bit 0)
            if (bus.mode[c]) begin
                all0_s[c] = rest0_s[c];
            end else begin
                all0_s[c] = rest0_s[c] & ~slice_s[c][0];
            end

            if (all1_s[c]) begin
                io_out_d[c] = 1'b1;
            end else if (all0_s[c]) begin
                io_out_d[c] = 1'b0;
            end else begin
                io_out_d[c] = io_out_q[c];
            end

            if (bus.clr_cnt) begin
                cnt_d[c] = '0;
            end else if ((io_out_d[c] != io_out_q[c]) && (cnt_q[c] != CNT_MAX)) begin
                cnt_d[c] = cnt_q[c] + CNT_ONE;
            end else begin
                cnt_d[c] = cnt_q[c];
            end

            if (all1_s[c] || all0_s[c]) begin
                stall_d[c] = '0;
            end else if (stall_q[c] != STALL_MAX) begin
                stall_d[c] = stall_q[c] + STALL_ONE;
            end else begin
                stall_d[c] = stall_q[c];
            end

            stuck_d[c] = (stall_d[c] == STALL_MAX);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            io_out_q <= {CHANNELS{RESET_VAL}};
            cnt_q    <= '0;
            stall_q  <= '0;
            stuck_q  <= '0;
        end else begin
            io_out_q <= io_out_d;
            cnt_q    <= cnt_d;
            stall_q  <= stall_d;
            stuck_q  <= stuck_d;
        end
    end

    assign bus.io_out     = io_out_q;
    assign bus.toggle_cnt = cnt_q;
    assign bus.stuck      = stuck_q;
endmodule

// File: doc/muller_c_bank.md
# muller_c_bank

Parametrised bank of clocked Muller C-elements: CHANNELS independent channels, each an INPUTS-wide C-element with a selectable symmetric or asymmetric mode. Each channel also has a saturating transition counter and a stall detector. This is the next generation of the project's single 6-input C-element experiment. It sits behind the user-project I/O (io_in / io_out) and gives formal cover and on-chip observation of handshake completion across several channels at once.

## Interface
- CHANNELS, 2: number of independent C-elements.
- INPUTS, 3: inputs per channel. Must be ≥ 2.
- RESET_VAL, 0: value every io_out bit takes in reset.
- CNT_W, 8: width of each transition counter.
- STALL_CYC, 15: consecutive disagreeing cycles before stuck asserts. Must be ≥ 1.

- clock  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- io_in  in  CHANNELS*INPUTS  channel c uses bits [c*INPUTS +: INPUTS]. Bit 0 of each slice is the "plus" input.
- mode  in  CHANNELS  per channel: 0 = symmetric, 1 = asymmetric.
- clr_cnt  in  1  synchronous clear of all transition counters.
- io_out  out  CHANNELS  registered C-element outputs.
- toggle_cnt  out  CHANNELS*CNT_W  channel c counter at [c*CNT_W +: CNT_W].
- stuck  out  CHANNELS  per-channel stall flag.

## Operation
- Per channel, per cycle, compute from the current io_in slice and mode:
  - all1 = AND of all INPUTS bits.
  - all0 = NOR of all bits in symmetric mode; NOR of bits [INPUTS-1:1] in asymmetric mode. In asymmetric mode the plus input is ignored for the fall.
- Next output: 1 if all1; else 0 if all0; else hold the current io_out.
- all1 and all0 cannot both be true. Asymmetric mode with plus=1 and the rest 0 gives all0, so the output falls.
- Disagree = neither all1 nor all0.
- Transition counter:
  - Increments by 1 when next io_out ≠ current io_out.
  - Saturates at 2^CNT_W−1.
  - clr_cnt wins over an increment in the same cycle: result is 0.
- Stall detector:
  - A per-channel counter of width clog2(STALL_CYC+1) counts consecutive disagree cycles and saturates at STALL_CYC.
  - It resets to 0 on any agreeing cycle.
  - stuck = 1 while the counter equals STALL_CYC.
  - stuck clears on the clock edge that follows the first agreeing cycle.
- Mode is sampled every cycle with no latching. A mode change affects the evaluation of that same cycle.
- Channels are fully independent. clr_cnt is global.

## Timing
- Reset (reset_n = 0 at a rising edge):
  - io_out = {CHANNELS{RESET_VAL}}.
  - All toggle_cnt = 0, all stall counters = 0, stuck = 0.
  - Reset overrides every input, including mid-handshake and mid-stall.
- Latency:
  - io_in → io_out: 1 cycle. Inputs sampled at edge N appear on io_out after edge N.
  - toggle_cnt updates on the same edge as io_out.
  - stuck asserts on the edge that completes STALL_CYC consecutive disagree samples, i.e. it is visible after the STALL_CYC-th disagreeing edge.
- All outputs are registered. No combinational path from inputs to outputs.
- Input change to agreement and back within one sample period is invisible. No asynchronous capture.

## Test plan
- Reset with io_in = 6'b010101, mode = 0: io_out = 2'b00, toggle_cnt = 0, stuck = 0. Release reset and hold inputs (ch0 = 101, ch1 = 010, both disagree): io_out stays 00, and stuck = 2'b11 exactly 15 cycles after release.
- Symmetric ch0: 000 → 111 → 011 → 000. Expected io_out[0] after each edge: 1, 1 (hold), 0. toggle_cnt[0] = 2.
- Asymmetric ch1 (mode = 2'b10): 111 → io_out[1] = 1. Then 001 (plus high, others low) → io_out[1] = 0. Symmetric mode with the same 001 holds at 1.
- Saturation with CNT_W = 2: toggle ch0 five times → toggle_cnt[0] = 3. Assert clr_cnt on the same cycle as a transition → 0.
- Stall recovery: reach stuck[0] = 1, then apply 111 → stuck[0] = 0 and io_out[0] = 1 after the next edge. Drop reset mid-stall → stuck = 0 and the stall count restarts from 0.
- Reset with RESET_VAL = 1: io_out = 2'b11. Inputs 010 on both channels → hold at 11. Inputs 000 → 00 one edge later, toggle_cnt = 1 per channel.
